msk_col_loader: RTL and testbench
=================================

MSK_COL_LOADER -- requirements
Module: msk_col_loader

Interface
REQ-001 Parameter d, default `DEFAULTSHARES (2), number of shares per bit.
REQ-002 Parameter count, default 32, data bits per column.
REQ-003 Parameter ncols, default 4, columns per block; a power of two, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  upstream column available.
REQ-007 in_ready  output  1  block accepts a column this cycle.
REQ-008 in_sh  input  count*d  masked column, opaque shared bus.
REQ-009 out_valid  output  1  a full block of ncols columns is held.
REQ-010 out_ready  input  1  downstream consumes the held block.
REQ-011 out_sh  output  ncols*count*d  held block; column k at bits [(k+1)*count*d-1 : k*count*d].

Function
REQ-012 The block SHALL accept a column when in_valid and in_ready are both 1 ("accept").
REQ-013 The block SHALL release the held block when out_valid and out_ready are both 1 ("release").
REQ-014 The control FSM SHALL have two states: FILL (counter-addressed loading) and FULL (block held).
REQ-015 In FILL, a column counter cnt (log2(ncols) bits) SHALL select the destination column; an accept writes in_sh into column cnt and increments cnt.
REQ-016 In FILL, an accept with cnt = ncols-1 SHALL wrap cnt to 0 and move the FSM to FULL on the next cycle.
REQ-017 out_valid SHALL be 1 exactly when the FSM is in FULL, and SHALL be registered, not combinational.
REQ-018 in_ready SHALL be 1 in FILL, and in FULL only when out_ready is 1.
REQ-019 On a release with in_valid = 0, the FSM SHALL return to FILL with cnt = 0.
REQ-020 On a release with a simultaneous accept, the FSM SHALL write in_sh into column 0, go to FILL, and set cnt to 1, so the stream loses no cycle.
REQ-021 Column k SHALL load only on the cycle of an accept targeting it, and SHALL hold its value on every other cycle.
REQ-022 Each column write enable SHALL be derived only from unshared control signals (in_valid, out_ready, cnt, FSM state), never from in_sh.
REQ-023 Shares SHALL NOT be combined, reordered, or recombined; each bit of in_sh maps 1:1 to its bit position within the target column.
REQ-024 Latency SHALL be: out_valid rises the cycle after the ncols-th accept; out_sh is stable for as long as out_valid is 1.
REQ-025 While out_valid = 1 and out_ready = 0, out_sh and all control state SHALL be frozen.

Reset
REQ-026 When rst is 1 at a clock edge, the FSM SHALL go to FILL with cnt = 0, so that out_valid = 0 and in_ready = 1.
REQ-027 Reset SHALL take priority over a simultaneous accept or release; a partial block in progress is discarded.
REQ-028 Column data registers SHALL NOT be reset; their contents after reset are don't-care until reloaded.

Structure
REQ-029 Each column SHALL be one instance of the existing masked enable-register gadget (d, count) driven by its decoded write enable.
REQ-030 The FSM and counter SHALL be plain unmasked logic in this module; no other sub-module is needed.
REQ-031 The FSM state encoding SHALL be localparams in this module; the share default SHALL come from the shared `DEFAULTSHARES define header; no new shared package SHALL be added.

Verification (d=2, count=32, ncols=4)
REQ-032 Reset, then four back-to-back accepts of columns C0..C3 -> out_valid = 1 on the cycle after the 4th accept, out_sh = {C3,C2,C1,C0}, in_ready = 0 while out_ready = 0.
REQ-033 Hold out_ready = 0 for 10 cycles while in_valid = 1 with changing in_sh -> out_sh unchanged, no accept occurs.
REQ-034 Full block held, out_ready = 1 and in_valid = 1 with D0 in the same cycle -> release, column 0 = D0, cnt = 1, out_valid = 0 next cycle.
REQ-035 Insert gaps of 0-3 cycles with in_valid = 0 between accepts -> out_sh is still the correct 4-column assembly; no column is written during a gap.
REQ-036 Assert rst after 2 accepts, then perform 4 new accepts -> out_sh holds only the 4 new columns; assert rst together with a release -> out_valid = 0 and cnt = 0.
REQ-037 Random shares per bit, compare share-XOR of out_sh against the unmasked reference over 1000 blocks -> all match; no individual share bit moves to a different position.

Source files
------------

// File: rtl/msk_col_loader_reg.sv
// Masked enable-register gadget: holds one column of d-share data, loading it
// bit-for-bit only when its enable is high.
module msk_col_loader_reg #(
  parameter int d     = 2,
  parameter int count = 32
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [count*d-1:0]   in_sh,
  output logic [count*d-1:0]   out_sh
);

  logic [count*d-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = in_sh;
  end

  // NOTE: share storage has no reset; its contents are rewritten before they are ever presented as a valid block.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign out_sh = data_q;

endmodule

// File: rtl/msk_col_loader.sv
// Assembles ncols masked columns into one held block with a valid/ready
// handshake on each side; shares pass through untouched into per-column gadgets.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_col_loader #(
  parameter int d     = `DEFAULTSHARES,
  parameter int count = 32,
  parameter int ncols = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [count*d-1:0]         in_sh,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ncols*count*d-1:0]   out_sh
);

  localparam int CW   = $clog2(ncols);
  localparam int COLW = count * d;

  localparam logic FILL = 1'b0;
  localparam logic FULL = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = CW'(ncols - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, release_blk;
  logic [CW-1:0] wr_idx;
  logic [ncols-1:0] col_we;

  assign in_ready    = (state_q == FILL) || out_ready;
  assign out_valid   = (state_q == FULL);
  assign accept      = in_valid && in_ready;
  assign release_blk = out_valid && out_ready;

  // An accept while FULL implies a release, and its column always restarts at 0.
  assign wr_idx = (state_q == FULL) ? '0 : cnt_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == FILL) begin
      if (accept) begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = FULL;
      end
    end else if (release_blk) begin
      state_d = FILL;
      cnt_d   = accept ? CNT_ONE : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar k = 0; k < ncols; k++) begin : g_col
    // Enable decode uses only unshared control, never the share data.
    assign col_we[k] = accept && (wr_idx == CW'(k));

    msk_col_loader_reg #(
      .d     (d),
      .count (count)
    ) u_col (
      .clk    (clk),
      .en     (col_we[k]),
      .in_sh  (in_sh),
      .out_sh (out_sh[k*COLW +: COLW])
    );
  end

endmodule

// File: tb/tb_msk_col_loader.sv
// Self-checking bench for msk_col_loader (d=2, count=32, ncols=4): block-level
// model compared every cycle, plus hand-computed directed expectations.
module tb_msk_col_loader;

  localparam int D   = 2;
  localparam int CNT = 32;
  localparam int NC  = 4;
  localparam int CW  = CNT * D;
  localparam int BW  = NC * CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_sh = '0;
  logic          in_ready;
  logic          out_valid;
  logic [BW-1:0] out_sh;

  msk_col_loader #(.d(D), .count(CNT), .ncols(NC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sh     (in_sh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sh    (out_sh)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Block-level model: a list of columns filled in arrival order; full at NC.
  bit             started = 1'b0;
  bit             m_full = 1'b0;
  int             m_n = 0;
  int             m_blocks = 0;
  logic [CW-1:0]  m_blk[NC];
  logic [CNT-1:0] m_plain[NC];
  bit             m_known[NC];
  logic [CNT-1:0] cur_plain = '0;

  always @(posedge clk) begin : model
    bit acc, rel;
    if (rst) begin
      m_full = 1'b0;
      m_n    = 0;
      foreach (m_known[k]) m_known[k] = 1'b0;
    end else begin
      acc = in_valid && (!m_full || out_ready);
      rel = m_full && out_ready;
      if (rel) begin
        m_full = 1'b0;
        m_n    = 0;
        m_blocks++;
      end
      if (acc) begin
        m_blk[m_n]   = in_sh;
        m_plain[m_n] = cur_plain;
        m_known[m_n] = 1'b1;
        m_n++;
        if (m_n == NC) begin
          m_full = 1'b1;
          m_n    = 0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [CW-1:0] col;
    if (started) begin
      check("out_valid", BW'(out_valid), BW'(m_full));
      check("in_ready", BW'(in_ready), BW'(!m_full || out_ready));
      for (int k = 0; k < NC; k++) begin
        col = out_sh[k*CW +: CW];
        if (m_known[k]) check($sformatf("col%0d", k), BW'(col), BW'(m_blk[k]));
        if (m_full) check($sformatf("xor%0d", k), BW'(col[CNT-1:0] ^ col[CW-1:CNT]), BW'(m_plain[k]));
      end
    end
  end

  task automatic cyc(input logic v, input logic [CW-1:0] sh, input logic ordy);
    in_valid  = v;
    in_sh     = sh;
    out_ready = ordy;
    cur_plain = sh[CNT-1:0] ^ sh[CW-1:CNT];
    @(posedge clk);
    #1;
  endtask

  localparam logic [CW-1:0] C0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [CW-1:0] C1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [CW-1:0] C2 = 64'hA5A5_0000_5A5A_FFFF;
  localparam logic [CW-1:0] C3 = 64'h1111_2222_3333_4444;
  localparam logic [CW-1:0] D0 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [CW-1:0] E1 = 64'h0000_0001_8000_0000;
  localparam logic [CW-1:0] E2 = 64'h7FFF_FFFF_0000_0002;
  localparam logic [CW-1:0] E3 = 64'hC3C3_3C3C_9696_6969;

  initial begin
    logic [CW-1:0] g[NC];
    logic [CW-1:0] j[NC];
    logic [CW-1:0] kk[NC];
    int gaps[NC];
    int base, cycles;
    logic [CNT-1:0] plain, s0;

    g[0] = 64'h1000_0000_0000_0001; g[1] = 64'h2000_0000_0000_0002;
    g[2] = 64'h3000_0000_0000_0003; g[3] = 64'h4000_0000_0000_0004;
    j[0] = 64'hAAAA_0000_0000_0010; j[1] = 64'hBBBB_0000_0000_0020;
    j[2] = 64'hCCCC_0000_0000_0030; j[3] = 64'hDDDD_0000_0000_0040;
    kk[0] = 64'h0F0F_0F0F_0000_0100; kk[1] = 64'hF0F0_F0F0_0000_0200;
    kk[2] = 64'h5555_5555_0000_0300; kk[3] = 64'h3333_3333_0000_0400;
    gaps = '{1, 3, 0, 2};

    // Reset state
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0);
    started = 1'b1;
    cyc(1'b1, C3, 1'b0);
    check("rst_out_valid", BW'(out_valid), BW'(0));
    check("rst_in_ready", BW'(in_ready), BW'(1));
    rst = 1'b0;

    // Four back-to-back accepts
    cyc(1'b1, C0, 1'b0);
    cyc(1'b1, C1, 1'b0);
    cyc(1'b1, C2, 1'b0);
    check("pre_full_out_valid", BW'(out_valid), BW'(0));
    cyc(1'b1, C3, 1'b0);
    check("full_out_valid", BW'(out_valid), BW'(1));
    check("full_data", out_sh, {C3, C2, C1, C0});
    check("full_in_ready", BW'(in_ready), BW'(0));

    // Stall with changing input
    repeat (10) cyc(1'b1, {$urandom, $urandom}, 1'b0);
    check("stall_data", out_sh, {C3, C2, C1, C0});
    check("stall_out_valid", BW'(out_valid), BW'(1));

    // Release with simultaneous accept
    cyc(1'b1, D0, 1'b1);
    check("rel_acc_out_valid", BW'(out_valid), BW'(0));
    check("rel_acc_col0", BW'(out_sh[CW-1:0]), BW'(D0));
    cyc(1'b1, E1, 1'b0);
    cyc(1'b1, E2, 1'b0);
    cyc(1'b1, E3, 1'b0);
    check("rel_acc_block", out_sh, {E3, E2, E1, D0});

    // Plain release, then gapped accepts
    cyc(1'b0, '0, 1'b1);
    check("rel_out_valid", BW'(out_valid), BW'(0));
    for (int i = 0; i < NC; i++) begin
      repeat (gaps[i]) cyc(1'b0, {$urandom, $urandom}, 1'b0);
      cyc(1'b1, g[i], 1'b0);
    end
    check("gap_block", out_sh, {g[3], g[2], g[1], g[0]});

    // Reset discards a partial block
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 64'h9999_9999_9999_9999, 1'b0);
    cyc(1'b1, 64'h8888_8888_8888_8888, 1'b0);
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < NC; i++) cyc(1'b1, j[i], 1'b0);
    check("post_rst_valid", BW'(out_valid), BW'(1));
    check("post_rst_block", out_sh, {j[3], j[2], j[1], j[0]});

    // Reset wins over release plus accept
    rst = 1'b1;
    cyc(1'b1, 64'h7777_7777_7777_7777, 1'b1);
    out_ready = 1'b0;
    #1;
    check("rst_rel_out_valid", BW'(out_valid), BW'(0));
    check("rst_rel_in_ready", BW'(in_ready), BW'(1));
    rst = 1'b0;
    for (int i = 0; i < NC; i++) cyc(1'b1, kk[i], 1'b0);
    check("rst_rel_block", out_sh, {kk[3], kk[2], kk[1], kk[0]});
    cyc(1'b0, '0, 1'b1);

    // Random shares, random handshakes, 1000 blocks
    base   = m_blocks;
    cycles = 0;
    while ((m_blocks - base) < 1000 && cycles < 30000) begin
      plain     = $urandom;
      s0        = $urandom;
      in_valid  = ($urandom_range(3) != 0);
      out_ready = $urandom_range(1) != 0;
      in_sh     = {plain ^ s0, s0};
      cur_plain = plain;
      @(posedge clk);
      #1;
      cycles++;
    end
    check("random_blocks", BW'(m_blocks - base), BW'(1000));

    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
